ucdp_clk_div: RTL and testbench



---
 rtl/ucdp_clk_div.sv | 164 ++++++++++++++++
 tb/tb_ucdp_clk_div.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ucdp_clk_div.sv
// Runtime-programmable integer clock divider with glitch-free start/stop and
// period-aligned divisor updates. Define UCDP_CLK_DIV_DUTY50_EN for exact 50% duty on odd ratios.
module ucdp_clk_div #(
  parameter int          WIDTH   = 4,
  parameter int unsigned DIV_RST = 32'd1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_req_i,
  output logic             div_ack_o,
  output logic [WIDTH-1:0] div_o,
  output logic             run_o,
  output logic             tick_o,
  output logic             clk_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // A programmed divisor of 0 behaves like 1.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] div);
    return (div == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : div;
  endfunction

  // High-phase length floor(R/2) with R = d+1, i.e. ceil(d/2).
  function automatic logic [WIDTH:0] half_ratio(input logic [WIDTH-1:0] div);
    logic [WIDTH-1:0] d;
    d = eff_div(div);
    return {2'b00, d[WIDTH-1:1]} + {{WIDTH{1'b0}}, d[0]};
  endfunction

  state_e           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [WIDTH-1:0] new_r, new_s;
  logic             pend_r, pend_s;
  logic             pos_r, pos_s;
  logic             tick_r, tick_s;
  logic             run_r, run_s;
  logic             ack_r, ack_s;
  logic             last_s;
  logic             apply_s;

  // Next-state, counter and divisor-handshake logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    div_s   = div_r;
    new_s   = new_r;
    pend_s  = pend_r;
    tick_s  = 1'b0;
    ack_s   = 1'b0;
    last_s  = (cnt_r == eff_div(div_r));
    apply_s = pend_r && ((state_r == IDLE) || last_s);

    // A request held after its ack is ignored for one cycle so it is not re-captured.
    if (apply_s) begin
      div_s  = new_r;
      ack_s  = 1'b1;
      pend_s = 1'b0;
    end else if (div_req_i && !pend_r && !ack_r) begin
      new_s  = div_i;
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end

    case (state_r)
      IDLE: begin
        cnt_s = {WIDTH{1'b0}};
        if (en_i) begin
          state_s = RUN;
          tick_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN, STOPPING: begin
        if (last_s) begin
          cnt_s = {WIDTH{1'b0}};
          if ((state_r == STOPPING) && !en_i) begin
            state_s = IDLE;
          end else begin
            tick_s  = 1'b1;
            state_s = en_i ? RUN : STOPPING;
          end
        end else begin
          cnt_s   = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
          state_s = en_i ? RUN : STOPPING;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {WIDTH{1'b0}};
      end
    endcase

    run_s = (state_s != IDLE);
    pos_s = run_s && ({1'b0, cnt_s} < half_ratio(div_s));
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= {WIDTH{1'b0}};
      div_r   <= WIDTH'(DIV_RST);
      new_r   <= {WIDTH{1'b0}};
      pend_r  <= 1'b0;
      pos_r   <= 1'b0;
      tick_r  <= 1'b0;
      run_r   <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      div_r   <= div_s;
      new_r   <= new_s;
      pend_r  <= pend_s;
      pos_r   <= pos_s;
      tick_r  <= tick_s;
      run_r   <= run_s;
      ack_r   <= ack_s;
    end
  end

`ifdef UCDP_CLK_DIV_DUTY50_EN
  logic neg_r;
  logic odd_r;

  // Half-cycle delayed copy of the high phase stretches odd ratios to 50% duty.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg_r <= 1'b0;
    end else begin
      neg_r <= pos_r;
    end
  end

  // Odd-ratio select changes together with the divisor, at a point where both phases are low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      odd_r <= 1'b0;
    end else begin
      odd_r <= (div_s != {WIDTH{1'b0}}) && (div_s[0] == 1'b0);
    end
  end

  assign clk_o = pos_r | (odd_r & neg_r);
`else
  assign clk_o = pos_r;
`endif

  assign div_ack_o = ack_r;
  assign div_o     = div_r;
  assign run_o     = run_r;
  assign tick_o    = tick_r;

endmodule

// File: tb/tb_ucdp_clk_div.sv
// Randomized self-checking bench for ucdp_clk_div against a period-level reference model.
module tb_ucdp_clk_div;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [3:0] div_i;
  logic       div_req_i;
  logic       div_ack_o;
  logic [3:0] div_o;
  logic       run_o;
  logic       tick_o;
  logic       clk_o;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: position inside the current output period plus handshake bookkeeping.
  bit m_run, m_stop, m_pend, m_ack, m_tick;
  int m_pos, m_div, m_new;

  ucdp_clk_div #(.WIDTH(4), .DIV_RST(1)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .div_i    (div_i),
    .div_req_i(div_req_i),
    .div_ack_o(div_ack_o),
    .div_o    (div_o),
    .run_o    (run_o),
    .tick_o   (tick_o),
    .clk_o    (clk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int ratio_of(input int d);
    return ((d == 0) ? 1 : d) + 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_pend = 0; m_ack = 0; m_tick = 0;
    m_pos = 0; m_div = 1; m_new = 0;
  endtask

  task automatic model_step();
    bit wrap, apply, cap;
    wrap  = m_run && (m_pos == ratio_of(m_div) - 1);
    apply = m_pend && (!m_run || wrap);
    cap   = div_req_i && !m_pend && !m_ack;
    m_ack = apply;
    if (apply) begin
      m_div  = m_new;
      m_pend = 0;
    end else if (cap) begin
      m_new  = div_i;
      m_pend = 1;
    end
    m_tick = 0;
    if (!m_run) begin
      if (en_i) begin
        m_run = 1; m_pos = 0; m_tick = 1; m_stop = 0;
      end
    end else if (wrap) begin
      if (m_stop && !en_i) begin
        m_run = 0; m_pos = 0;
      end else begin
        m_pos = 0; m_tick = 1; m_stop = !en_i;
      end
    end else begin
      m_pos++;
      m_stop = !en_i;
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    check_eq("clk_o",  clk_o, (m_run && (m_pos < ratio_of(m_div) / 2)) ? 1 : 0);
    check_eq("tick_o", tick_o, m_tick);
    check_eq("run_o",  run_o, m_run);
    check_eq("ack_o",  div_ack_o, m_ack);
    check_eq("div_o",  div_o, m_div);
  endtask

  task automatic req_div(input int d);
    bit seen = 0;
    div_i     = d[3:0];
    div_req_i = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (div_ack_o) seen = 1;
    end
    div_req_i = 1'b0;
    check_eq("ack_seen", seen, 1);
  endtask

  // Measures one full output period between consecutive ticks.
  task automatic measure_period(input int exp);
    bit got = 0, done = 0;
    int len = 0, high = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (tick_o) got = 1;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      if (clk_o) high++;
      cycle();
      len++;
      if (tick_o) done = 1;
    end
    check_eq("period", len, exp);
    check_eq("high_time", high, exp / 2);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; div_req_i = 1'b0; div_i = 4'd0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_clk", clk_o, 0);
    check_eq("rst_run", run_o, 0);
    check_eq("rst_tick", tick_o, 0);
    check_eq("rst_div", div_o, 1);
    rst_i = 1'b0;

    en_i = 1'b1;
    repeat (6) cycle();
    measure_period(2);

    req_div(4);
    check_eq("div4", div_o, 4);
    measure_period(5);

    // Stop mid-period at ratio 4, then re-raise enable during a stopping period.
    req_div(3);
    cycle();
    en_i = 1'b0;
    repeat (6) cycle();
    check_eq("stopped", run_o, 0);
    en_i = 1'b1;
    repeat (3) cycle();
    measure_period(4);
    en_i = 1'b0;
    cycle();
    en_i = 1'b1;
    repeat (8) cycle();
    measure_period(4);

    req_div(0);
    measure_period(2);
    req_div(15);
    measure_period(16);

    // Asynchronous reset in the middle of a high phase.
    req_div(5);
    for (int i = 0; i < 20 && !clk_o; i++) cycle();
    check_eq("pre_rst_high", clk_o, 1);
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("arst_clk", clk_o, 0);
    check_eq("arst_run", run_o, 0);
    check_eq("arst_tick", tick_o, 0);
    check_eq("arst_div", div_o, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    repeat (6) cycle();
    measure_period(2);

    // Divisor update while idle.
    en_i = 1'b0;
    repeat (4) cycle();
    req_div(7);
    check_eq("div7", div_o, 7);
    en_i = 1'b1;
    repeat (3) cycle();
    measure_period(8);

    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (div_req_i && div_ack_o) begin
        div_req_i = 1'b0;
      end else if (!div_req_i && $urandom_range(0, 11) == 0) begin
        div_i     = 4'($urandom_range(0, 15));
        div_req_i = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) en_i = ~en_i;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
